// File: rtl/alu_nbit_seq_pkg.sv
// rtl/alu_nbit_seq_pkg.sv - opcode constants, FSM states and helpers for alu_nbit_seq
package alu_nbit_seq_pkg;

  localparam logic [3:0] OP_NOTA  = 4'd0;
  localparam logic [3:0] OP_NOTB  = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_XNOR  = 4'd5;
  localparam logic [3:0] OP_ADD   = 4'd6;
  localparam logic [3:0] OP_SUB   = 4'd7;
  localparam logic [3:0] OP_ADC   = 4'd8;
  localparam logic [3:0] OP_SBC   = 4'd9;
  localparam logic [3:0] OP_SHL   = 4'd10;
  localparam logic [3:0] OP_SHR   = 4'd11;
  localparam logic [3:0] OP_ASR   = 4'd12;
  localparam logic [3:0] OP_MUL   = 4'd13;
  localparam logic [3:0] OP_CMP   = 4'd14;
  localparam logic [3:0] OP_PASSB = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  function automatic logic is_sub_op(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/alu_nbit_seq_comb.sv
// rtl/alu_nbit_seq_comb.sv - single-cycle datapath: logic ops, adder with c/v, shifter
module alu_nbit_seq_comb
  import alu_nbit_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             cin,
  output logic [WIDTH-1:0] res,
  output logic             c,
  output logic             v
);

  logic [WIDTH-1:0] w_bx;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_c_into_msb;

  always_comb begin
    w_bx = is_sub_op(op) ? ~b : b;
    case (op)
      OP_ADD:         w_cin = 1'b0;
      OP_SUB, OP_CMP: w_cin = 1'b1;
      default:        w_cin = cin;
    endcase
  end

  assign w_sum = {1'b0, a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_cin};
  // Carry into the MSB recovered from the MSB sum bit and its two addend bits.
  assign w_c_into_msb = w_sum[WIDTH-1] ^ a[WIDTH-1] ^ w_bx[WIDTH-1];

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_NOTA:  res = ~a;
      OP_NOTB:  res = ~b;
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_XNOR:  res = ~(a ^ b);
      OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_CMP: begin
        res = (op == OP_CMP) ? a : w_sum[WIDTH-1:0];
        c   = w_sum[WIDTH];
        v   = w_c_into_msb ^ w_sum[WIDTH];
      end
      OP_SHL: begin
        res = {a[WIDTH-2:0], 1'b0};
        c   = a[WIDTH-1];
      end
      OP_SHR: begin
        res = {1'b0, a[WIDTH-1:1]};
        c   = a[0];
      end
      OP_ASR: begin
        res = {a[WIDTH-1], a[WIDTH-1:1]};
        c   = a[0];
      end
      OP_PASSB: res = b;
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/alu_nbit_seq.sv
// rtl/alu_nbit_seq.sv - registered N-bit ALU with valid/ready handshake and shift-add multiply
module alu_nbit_seq
  import alu_nbit_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v
);

  localparam int CW = $clog2(WIDTH);

  state_t             r_state, w_state_next;
  logic [2*WIDTH-1:0] r_mul_a, r_acc, w_acc_next;
  logic [WIDTH-1:0]   r_mul_b;
  logic [CW-1:0]      r_cnt;
  logic               r_cf, r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_c, r_n, r_z, r_v;
  logic               w_accept, w_mul_done;
  logic [WIDTH-1:0]   w_res;
  logic               w_c, w_v;

  alu_nbit_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .a   (a),
    .b   (b),
    .op  (op),
    .cin (r_cf),
    .res (w_res),
    .c   (w_c),
    .v   (w_v)
  );

  assign in_ready   = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_acc_next = r_mul_b[0] ? r_acc + r_mul_a : r_acc;

  always_comb begin
    w_state_next = r_state;
    w_mul_done   = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept && (op == OP_MUL)) w_state_next = ST_MUL;
      ST_MUL: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_mul_done   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_cf        <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_c         <= 1'b0;
      r_n         <= 1'b0;
      r_z         <= 1'b0;
      r_v         <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_accept && (op == OP_MUL)) begin
        r_mul_a <= {{WIDTH{1'b0}}, a};
        r_mul_b <= b;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (r_state == ST_MUL) begin
        r_acc   <= w_acc_next;
        r_mul_a <= r_mul_a << 1;
        r_mul_b <= r_mul_b >> 1;
        r_cnt   <= r_cnt + 1'b1;
      end

      // The out reg is always empty while multiplying, since accept required it free.
      if (w_mul_done) begin
        r_result    <= w_acc_next[WIDTH-1:0];
        r_c         <= |w_acc_next[2*WIDTH-1:WIDTH];
        r_cf        <= |w_acc_next[2*WIDTH-1:WIDTH];
        r_v         <= 1'b0;
        r_n         <= w_acc_next[WIDTH-1];
        r_z         <= ~|w_acc_next[WIDTH-1:0];
        r_out_valid <= 1'b1;
      end else if (w_accept && (op != OP_MUL)) begin
        r_result    <= w_res;
        r_c         <= w_c;
        r_cf        <= w_c;
        r_v         <= w_v;
        r_n         <= w_res[WIDTH-1];
        r_z         <= ~|w_res;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign c         = r_c;
  assign n         = r_n;
  assign z         = r_z;
  assign v         = r_v;

endmodule

// File: tb/tb_alu_nbit_seq.sv
// tb/tb_alu_nbit_seq.sv - self-checking bench for alu_nbit_seq at WIDTH=8
module tb_alu_nbit_seq;
  import alu_nbit_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, result;
  logic [3:0] op;
  logic       c, n, z, v;

  int          n_err = 0;
  int          n_checks = 0;
  logic        m_cf = 1'b0;
  logic [11:0] last_obs;
  logic [11:0] e;

  always #5 clk = ~clk;

  alu_nbit_seq #(.WIDTH(8), .OPW(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .c(c), .n(n), .z(z), .v(v)
  );

  // Reference: {result[7:0], c, n, z, v} from plain integer arithmetic.
  function automatic logic [11:0] model(input logic [3:0] o, input logic [7:0] x, y, input logic cf);
    logic [7:0] r, yb;
    logic       cc, vv, ci;
    int         s, p;
    r = 8'h00; cc = 1'b0; vv = 1'b0;
    case (o)
      4'd0:  r = ~x;
      4'd1:  r = ~y;
      4'd2:  r = x & y;
      4'd3:  r = x | y;
      4'd4:  r = x ^ y;
      4'd5:  r = ~(x ^ y);
      4'd6, 4'd7, 4'd8, 4'd9, 4'd14: begin
        yb = (o == 4'd7 || o == 4'd9 || o == 4'd14) ? ~y : y;
        ci = (o == 4'd6) ? 1'b0 : (o == 4'd7 || o == 4'd14) ? 1'b1 : cf;
        s  = int'(x) + int'(yb) + int'(ci);
        r  = s[7:0];
        cc = (s > 255);
        vv = (x[7] == yb[7]) && (r[7] != x[7]);
        if (o == 4'd14) r = x;
      end
      4'd10: begin r = x << 1; cc = x[7]; end
      4'd11: begin r = x >> 1; cc = x[0]; end
      4'd12: begin r = 8'($signed(x) >>> 1); cc = x[0]; end
      4'd13: begin p = int'(x) * int'(y); r = p[7:0]; cc = (p > 255); end
      default: r = y;
    endcase
    return {r, cc, r[7], (r == 8'h00), vv};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, input string tag);
    logic [11:0] ex;
    int          w, lat;
    ex = model(o, x, y, m_cf);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
    w = 0;
    while (!in_ready && w < 40) begin @(negedge clk); w++; end
    check({tag, "_accept"}, 32'(w < 40), 1);
    @(negedge clk);
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      check({tag, "_busy_in_ready"}, in_ready, 0);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, (o == OP_MUL) ? 9 : 1);
    last_obs = {result, c, n, z, v};
    check(tag, last_obs, ex);
    m_cf = ex[3];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {out_valid, result, c, n, z, v}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);

    run_op(OP_ADD, 8'h7F, 8'h01, "add_ovf");
    check("add_ovf_const", last_obs, 12'h805);
    run_op(OP_SUB, 8'h05, 8'h05, "sub_eq");
    check("sub_eq_const", last_obs, 12'h00A);
    run_op(OP_ADD, 8'hFF, 8'h01, "add_carry");
    check("add_carry_const", last_obs, 12'h00A);
    run_op(OP_ADC, 8'h00, 8'h00, "adc_cf1");
    check("adc_cf1_const", last_obs, 12'h010);
    run_op(OP_SUB, 8'h03, 8'h05, "sub_borrow");
    check("sub_borrow_const", last_obs, 12'hFE4);
    run_op(OP_SBC, 8'h05, 8'h01, "sbc_cf0");
    check("sbc_cf0_const", last_obs, 12'h038);
    run_op(OP_MUL, 8'h0D, 8'h0B, "mul_0d_0b");
    check("mul_0d_0b_const", last_obs, 12'h8F4);
    run_op(OP_MUL, 8'h10, 8'h10, "mul_ovf");
    check("mul_ovf_const", last_obs, 12'h00A);
    run_op(OP_ASR, 8'h81, 8'h00, "asr");
    check("asr_const", last_obs, 12'hC0C);
    run_op(OP_SHR, 8'h81, 8'h00, "shr");
    check("shr_const", last_obs, 12'h408);
    run_op(OP_SHL, 8'h81, 8'h00, "shl");
    check("shl_const", last_obs, 12'h028);

    // Back-pressure hold followed by back-to-back throughput.
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_idle", out_valid, 0);
    op = OP_ADD; a = 8'h03; b = 8'h04; in_valid = 1'b1; out_ready = 1'b0;
    e = model(op, a, b, m_cf); m_cf = e[3];
    @(negedge clk);
    check("bp_first_valid", out_valid, 1);
    check("bp_first", {result, c, n, z, v}, e);
    op = OP_XOR; a = 8'h55; b = 8'h0F;
    for (int k = 0; k < 5; k++) begin
      check("bp_hold", {result, c, n, z, v}, e);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] nop;
      e = model(op, a, b, m_cf); m_cf = e[3];
      @(negedge clk);
      check("b2b_valid", out_valid, 1);
      check("b2b_result", {result, c, n, z, v}, e);
      nop = 4'($urandom_range(0, 14));
      if (nop >= OP_MUL) nop = nop + 4'd1;
      op = nop; a = 8'($urandom); b = 8'($urandom);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_drain", out_valid, 0);

    for (int k = 0; k < 40; k++) begin
      run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), "random");
    end

    // Reset in the middle of a multiply after setting Cf.
    run_op(OP_ADD, 8'hFF, 8'h01, "pre_reset_cf");
    @(negedge clk);
    in_valid = 1'b1; op = OP_MUL; a = 8'h33; b = 8'h77; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("mul_started", in_ready, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midmul_reset_state", {out_valid, result, c, n, z, v}, 0);
    reset = 1'b0;
    m_cf = 1'b0;
    @(negedge clk);
    check("midmul_in_ready", in_ready, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("midmul_discarded", out_valid, 0);
    end
    run_op(OP_ADC, 8'h01, 8'h01, "adc_after_reset");
    check("adc_after_reset_const", last_obs, 12'h020);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
